// File: rtl/bp_io_cmd_arbiter_pkg.sv
// Shared types for the I/O command arbiter: memory message layout, config selector and width helpers.
// Consumed by bp_io_cmd_arbiter and bp_io_arb_tag_fifo via import bp_io_cmd_arbiter_pkg::*.
package bp_io_cmd_arbiter_pkg;

  typedef enum logic [1:0] {
    e_bp_inv_cfg,
    e_bp_unicore_cfg,
    e_bp_multicore_1_cfg
  } bp_params_e;

  localparam int paddr_width_p       = 40;
  localparam int cce_block_width_p   = 64;
  localparam int cce_payload_width_p = 16;

  localparam logic [paddr_width_p-1:0] io_putchar_addr_lp = 40'h00_0010_1000;
  localparam logic [paddr_width_p-1:0] io_getchar_addr_lp = 40'h00_0010_0000;
  localparam logic [paddr_width_p-1:0] io_finish_addr_lp  = 40'h00_0010_2000;

  typedef enum logic [3:0] {
    e_mem_msg_rd    = 4'd0,
    e_mem_msg_wr    = 4'd1,
    e_mem_msg_uc_rd = 4'd2,
    e_mem_msg_uc_wr = 4'd3
  } bp_mem_msg_e;

  typedef enum logic [2:0] {
    e_mem_msg_size_1 = 3'd0,
    e_mem_msg_size_2 = 3'd1,
    e_mem_msg_size_4 = 3'd2,
    e_mem_msg_size_8 = 3'd3
  } bp_mem_msg_size_e;

  typedef struct packed {
    logic [cce_block_width_p-1:0]   data;
    logic [cce_payload_width_p-1:0] payload;
    bp_mem_msg_size_e               size;
    logic [paddr_width_p-1:0]       addr;
    bp_mem_msg_e                    msg_type;
  } bp_cce_mem_msg_s;

  localparam int cce_mem_msg_width_lp = $bits(bp_cce_mem_msg_s);

  // Every supported config currently shares one message layout.
  function automatic int msg_width(bp_params_e cfg);
    case (cfg)
      e_bp_inv_cfg: return cce_mem_msg_width_lp;
      default:      return cce_mem_msg_width_lp;
    endcase
  endfunction

  // Never returns 0, so a single-entry quantity still gets a 1-bit field.
  function automatic int safe_clog2(int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bp_io_arb_tag_fifo.sv
// Circular FIFO of source tags for in-flight I/O commands; push v_i/ready_o, pop v_o/yumi_i.
// No push-to-pop bypass: a tag becomes visible on the cycle after it is written.
module bp_io_arb_tag_fifo
  import bp_io_cmd_arbiter_pkg::*;
#(
  parameter int width_p = 1,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i
);

  localparam int ptr_w = safe_clog2(els_p);
  localparam int cnt_w = $clog2(els_p + 1);

  logic [width_p-1:0] mem_q [els_p];
  logic [ptr_w-1:0]   head_q, head_d, tail_q, tail_d;
  logic [cnt_w-1:0]   cnt_q, cnt_d;
  logic               push, pop;

  assign ready_o = (cnt_q != cnt_w'(els_p));
  assign v_o     = (cnt_q != '0);
  assign data_o  = mem_q[head_q];
  assign push    = v_i & ready_o;
  assign pop     = yumi_i & v_o;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (pop) begin
      head_d = (head_q == ptr_w'(els_p - 1)) ? '0 : head_q + ptr_w'(1);
    end
    if (push) begin
      tail_d = (tail_q == ptr_w'(els_p - 1)) ? '0 : tail_q + ptr_w'(1);
    end
    if (push & ~pop) begin
      cnt_d = cnt_q + cnt_w'(1);
    end else if (pop & ~push) begin
      cnt_d = cnt_q - cnt_w'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[tail_q] <= data_i;
    end
  end

endmodule

// File: rtl/bp_io_cmd_arbiter.sv
// Round-robin merge of per-core I/O commands onto one host port, with in-order response routing.
// Optional BP_IO_ARB_STATS_EN adds grant/response counters and an orphan-response flag.
module bp_io_cmd_arbiter
  import bp_io_cmd_arbiter_pkg::*;
#(
  parameter bp_params_e bp_params_p       = e_bp_inv_cfg,
  parameter int         num_src_p         = 2,
  parameter int         max_outstanding_p = 4,
  localparam int        msg_w             = msg_width(bp_params_p)
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [num_src_p*msg_w-1:0]   src_cmd_i,
  input  logic [num_src_p-1:0]         src_cmd_v_i,
  output logic [num_src_p-1:0]         src_cmd_ready_o,
  output logic [msg_w-1:0]             src_resp_o,
  output logic [num_src_p-1:0]         src_resp_v_o,
  input  logic [num_src_p-1:0]         src_resp_yumi_i,
  output logic [msg_w-1:0]             io_cmd_o,
  output logic                         io_cmd_v_o,
  input  logic                         io_cmd_ready_i,
  input  logic [msg_w-1:0]             io_resp_i,
  input  logic                         io_resp_v_i,
  output logic                         io_resp_yumi_o
);

  localparam int lg_num_src = safe_clog2(num_src_p);
  typedef logic [lg_num_src-1:0] bp_io_src_tag_t;

  logic [msg_w-1:0] src_msg [num_src_p];
  bp_io_src_tag_t   rr_q, rr_d, win, tag_head;
  logic             any_v, grant_en, xfer, tag_ready, tag_v, resp_v, found;
  int               idx;

  genvar gi;
  generate
    for (gi = 0; gi < num_src_p; gi++) begin : g_src
      assign src_msg[gi]         = src_cmd_i[gi*msg_w +: msg_w];
      assign src_cmd_ready_o[gi] = grant_en & any_v & (win == bp_io_src_tag_t'(gi));
      assign src_resp_v_o[gi]    = resp_v & (tag_head == bp_io_src_tag_t'(gi));
    end
  endgenerate

  // First valid source at or above the pointer, wrapping past the top.
  always_comb begin
    win   = rr_q;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < num_src_p; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= num_src_p) begin
        idx = idx - num_src_p;
      end
      if (!found && src_cmd_v_i[idx[lg_num_src-1:0]]) begin
        found = 1'b1;
        win   = bp_io_src_tag_t'(idx);
      end
    end
  end

  // reset_n_i gates grant so nothing is offered to the host while reset is held.
  assign any_v      = |src_cmd_v_i;
  assign grant_en   = reset_n_i & io_cmd_ready_i & tag_ready;
  assign io_cmd_v_o = grant_en & any_v;
  assign io_cmd_o   = src_msg[win];
  assign xfer       = io_cmd_v_o;

  always_comb begin
    rr_d = rr_q;
    if (xfer) begin
      rr_d = (win == bp_io_src_tag_t'(num_src_p - 1)) ? '0 : win + bp_io_src_tag_t'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

  bp_io_arb_tag_fifo #(
    .width_p (lg_num_src),
    .els_p   (max_outstanding_p)
  ) tag_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .data_i    (win),
    .v_i       (xfer),
    .ready_o   (tag_ready),
    .data_o    (tag_head),
    .v_o       (tag_v),
    .yumi_i    (io_resp_yumi_o)
  );

  // A response without a tag is never routed; it waits at the host port.
  assign resp_v         = io_resp_v_i & tag_v;
  assign src_resp_o     = io_resp_i;
  assign io_resp_yumi_o = |(src_resp_v_o & src_resp_yumi_i);

`ifdef BP_IO_ARB_STATS_EN
  logic [31:0] grant_cnt_q [num_src_p];
  logic [31:0] grant_cnt_d [num_src_p];
  logic [31:0] resp_cnt_q  [num_src_p];
  logic [31:0] resp_cnt_d  [num_src_p];
  logic        orphan_resp_r, orphan_set;

  assign orphan_set = reset_n_i & io_resp_v_i & ~tag_v;

  always_comb begin
    for (int i = 0; i < num_src_p; i++) begin
      grant_cnt_d[i] = grant_cnt_q[i];
      resp_cnt_d[i]  = resp_cnt_q[i];
      if (src_cmd_ready_o[i] & src_cmd_v_i[i] & ~&grant_cnt_q[i]) begin
        grant_cnt_d[i] = grant_cnt_q[i] + 32'd1;
      end
      if (src_resp_v_o[i] & src_resp_yumi_i[i] & ~&resp_cnt_q[i]) begin
        resp_cnt_d[i] = resp_cnt_q[i] + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < num_src_p; i++) begin
        grant_cnt_q[i] <= '0;
        resp_cnt_q[i]  <= '0;
      end
      orphan_resp_r <= 1'b0;
    end else begin
      for (int i = 0; i < num_src_p; i++) begin
        grant_cnt_q[i] <= grant_cnt_d[i];
        resp_cnt_q[i]  <= resp_cnt_d[i];
      end
      orphan_resp_r <= orphan_resp_r | orphan_set;
    end
  end

  always @(posedge clk_i) begin
    if (orphan_set && !orphan_resp_r) begin
      $error("bp_io_cmd_arbiter: host response with no outstanding tag");
    end
  end

  final begin
    for (int i = 0; i < num_src_p; i++) begin
      $display("bp_io_cmd_arbiter src%0d grants=%0d resps=%0d", i, grant_cnt_q[i], resp_cnt_q[i]);
    end
    $display("bp_io_cmd_arbiter orphan_resp=%0b", orphan_resp_r);
  end
`endif

endmodule

// File: tb/tb_bp_io_cmd_arbiter.sv
// Directed bench for bp_io_cmd_arbiter (2 sources, 4 outstanding): arbitration, tag-full stall,
// in-order response routing, yumi filtering, and asynchronous reset mid-traffic.
module tb_bp_io_cmd_arbiter;
  import bp_io_cmd_arbiter_pkg::*;

  localparam int n     = 2;
  localparam int msg_w = cce_mem_msg_width_lp;

  logic               clk_i = 1'b0;
  logic               reset_n_i;
  logic [n*msg_w-1:0] src_cmd_i;
  logic [n-1:0]       src_cmd_v_i, src_cmd_ready_o, src_resp_v_o, src_resp_yumi_i;
  logic [msg_w-1:0]   src_resp_o, io_cmd_o, io_resp_i;
  logic               io_cmd_v_o, io_cmd_ready_i, io_resp_v_i, io_resp_yumi_o;

  int errors = 0;
  int checks = 0;

  logic [msg_w-1:0] m0, m1, ma, mb, ra, rb;
  logic [msg_w-1:0] rsp [4];

  always #5 clk_i = ~clk_i;

  bp_io_cmd_arbiter #(
    .bp_params_p       (e_bp_inv_cfg),
    .num_src_p         (n),
    .max_outstanding_p (4)
  ) dut (
    .clk_i           (clk_i),
    .reset_n_i       (reset_n_i),
    .src_cmd_i       (src_cmd_i),
    .src_cmd_v_i     (src_cmd_v_i),
    .src_cmd_ready_o (src_cmd_ready_o),
    .src_resp_o      (src_resp_o),
    .src_resp_v_o    (src_resp_v_o),
    .src_resp_yumi_i (src_resp_yumi_i),
    .io_cmd_o        (io_cmd_o),
    .io_cmd_v_o      (io_cmd_v_o),
    .io_cmd_ready_i  (io_cmd_ready_i),
    .io_resp_i       (io_resp_i),
    .io_resp_v_i     (io_resp_v_i),
    .io_resp_yumi_o  (io_resp_yumi_o)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  function automatic logic [msg_w-1:0] mk_msg(input logic [39:0] addr, input logic [63:0] data);
    bp_cce_mem_msg_s m;
    m.msg_type = e_mem_msg_uc_wr;
    m.size     = e_mem_msg_size_1;
    m.addr     = addr;
    m.payload  = 16'h0;
    m.data     = data;
    return m;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    m0 = mk_msg(io_finish_addr_lp, 64'h1111);
    m1 = mk_msg(io_getchar_addr_lp, 64'h2222);
    ma = mk_msg(io_putchar_addr_lp, 64'h41);
    mb = mk_msg(io_putchar_addr_lp + 40'h8, 64'h42);
    ra = mk_msg(io_putchar_addr_lp, {24'h0, io_putchar_addr_lp});
    rb = mk_msg(io_putchar_addr_lp + 40'h8, {24'h0, io_putchar_addr_lp + 40'h8});
    for (int k = 0; k < 4; k++) rsp[k] = mk_msg(40'h100 + 40'(k), 64'(k + 16));

    // Reset held with every input asserted: all handshake outputs must be low.
    reset_n_i       = 1'b0;
    src_cmd_i       = {m1, m0};
    src_cmd_v_i     = 2'b11;
    io_cmd_ready_i  = 1'b1;
    io_resp_v_i     = 1'b1;
    io_resp_i       = rsp[0];
    src_resp_yumi_i = 2'b11;
    #2;
    check("rst_ready", src_cmd_ready_o, 2'b00);
    check("rst_io_cmd_v", io_cmd_v_o, 1'b0);
    check("rst_resp_v", src_resp_v_o, 2'b00);
    check("rst_io_resp_yumi", io_resp_yumi_o, 1'b0);
    tick();
    tick();
    reset_n_i       = 1'b1;
    src_cmd_v_i     = 2'b00;
    io_resp_v_i     = 1'b0;
    src_resp_yumi_i = 2'b00;

    // Test 1: both sources valid -> grants alternate 0,1,0,1, then full.
    tick();
    src_cmd_v_i = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t1_io_cmd_v_%0d", k), io_cmd_v_o, 1'b1);
      check($sformatf("t1_ready_%0d", k), src_cmd_ready_o, (k % 2 == 0) ? 2'b01 : 2'b10);
      check($sformatf("t1_io_cmd_%0d", k), io_cmd_o, (k % 2 == 0) ? m0 : m1);
      tick();
      #1;
    end
    check("t1_full_io_cmd_v", io_cmd_v_o, 1'b0);
    check("t1_full_ready", src_cmd_ready_o, 2'b00);
    src_cmd_v_i     = 2'b00;
    io_resp_v_i     = 1'b1;
    src_resp_yumi_i = 2'b11;
    for (int k = 0; k < 4; k++) begin
      io_resp_i = rsp[k];
      #1;
      check($sformatf("t1_resp_v_%0d", k), src_resp_v_o, (k % 2 == 0) ? 2'b01 : 2'b10);
      check($sformatf("t1_resp_data_%0d", k), src_resp_o, rsp[k]);
      check($sformatf("t1_io_resp_yumi_%0d", k), io_resp_yumi_o, 1'b1);
      tick();
    end
    #1;
    check("t1_orphan_resp_v", src_resp_v_o, 2'b00);
    check("t1_orphan_yumi", io_resp_yumi_o, 1'b0);
    io_resp_v_i     = 1'b0;
    src_resp_yumi_i = 2'b00;

    // Test 2 (with test 4): five commands from src1 against four tag slots.
    tick();
    src_cmd_v_i = 2'b10;
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t2_ready_%0d", k), src_cmd_ready_o, 2'b10);
      tick();
      #1;
    end
    check("t2_full_ready", src_cmd_ready_o, 2'b00);
    check("t2_full_io_cmd_v", io_cmd_v_o, 1'b0);
    io_resp_v_i     = 1'b1;
    io_resp_i       = rsp[1];
    src_resp_yumi_i = 2'b01;
    #1;
    check("t4_wrong_yumi_resp_v", src_resp_v_o, 2'b10);
    check("t4_wrong_yumi_io_yumi", io_resp_yumi_o, 1'b0);
    tick();
    src_resp_yumi_i = 2'b10;
    #1;
    check("t4_right_yumi_io_yumi", io_resp_yumi_o, 1'b1);
    check("t2_pop_full_ready", src_cmd_ready_o, 2'b00);
    tick();
    io_resp_v_i     = 1'b0;
    src_resp_yumi_i = 2'b00;
    #1;
    check("t2_fifth_ready", src_cmd_ready_o, 2'b10);
    check("t2_fifth_io_cmd_v", io_cmd_v_o, 1'b1);
    tick();
    src_cmd_v_i     = 2'b00;
    io_resp_v_i     = 1'b1;
    src_resp_yumi_i = 2'b10;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("t2_drain_resp_v_%0d", k), src_resp_v_o, 2'b10);
      tick();
    end
    #1;
    check("t2_drained_resp_v", src_resp_v_o, 2'b00);
    io_resp_v_i     = 1'b0;
    src_resp_yumi_i = 2'b00;

    // Test 3: putchar 'A' from src0 then 'B' from src1; a response in the push cycle is not bypassed.
    tick();
    src_cmd_i       = {mb, ma};
    src_cmd_v_i     = 2'b01;
    io_resp_v_i     = 1'b1;
    io_resp_i       = ra;
    src_resp_yumi_i = 2'b11;
    #1;
    check("t3_a_ready", src_cmd_ready_o, 2'b01);
    check("t3_a_io_cmd", io_cmd_o, ma);
    check("t3_nobypass_resp_v", src_resp_v_o, 2'b00);
    check("t3_nobypass_yumi", io_resp_yumi_o, 1'b0);
    tick();
    src_cmd_v_i = 2'b10;
    io_resp_v_i = 1'b0;
    #1;
    check("t3_b_ready", src_cmd_ready_o, 2'b10);
    check("t3_b_io_cmd", io_cmd_o, mb);
    tick();
    src_cmd_v_i = 2'b00;
    io_resp_v_i = 1'b1;
    io_resp_i   = ra;
    #1;
    check("t3_a_resp_v", src_resp_v_o, 2'b01);
    check("t3_a_resp_data", src_resp_o, ra);
    tick();
    io_resp_i = rb;
    #1;
    check("t3_b_resp_v", src_resp_v_o, 2'b10);
    check("t3_b_resp_data", src_resp_o, rb);
    tick();
    io_resp_v_i     = 1'b0;
    src_resp_yumi_i = 2'b00;

    // Test 5: three tags in flight (pointer left at 1), then asynchronous reset.
    src_cmd_i   = {m1, m0};
    src_cmd_v_i = 2'b11;
    tick();
    tick();
    tick();
    src_cmd_v_i     = 2'b00;
    io_resp_v_i     = 1'b1;
    src_resp_yumi_i = 2'b11;
    #1;
    check("t5_pre_resp_v", src_resp_v_o, 2'b01);
    src_cmd_v_i = 2'b11;
    reset_n_i   = 1'b0;
    #1;
    check("t5_rst_ready", src_cmd_ready_o, 2'b00);
    check("t5_rst_io_cmd_v", io_cmd_v_o, 1'b0);
    check("t5_rst_resp_v", src_resp_v_o, 2'b00);
    check("t5_rst_io_resp_yumi", io_resp_yumi_o, 1'b0);
    tick();
    tick();
    reset_n_i = 1'b1;
    #1;
    check("t5_post_ready_rr0", src_cmd_ready_o, 2'b01);
    check("t5_post_resp_v_empty", src_resp_v_o, 2'b00);
    check("t5_post_io_resp_yumi", io_resp_yumi_o, 1'b0);
    tick();
    src_cmd_v_i     = 2'b00;
    io_resp_v_i     = 1'b0;
    src_resp_yumi_i = 2'b00;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
